// File: rtl/p6_pkg.sv
// Shared encodings for the p6 branch unit: branch types, condition codes and FSM states.
package p6_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_L    = 2'b01,
        BR_X    = 2'b10,
        BR_LX   = 2'b11
    } br_type_e;

    typedef enum logic [2:0] {
        C_AL = 3'b000,
        C_EQ = 3'b001,
        C_NE = 3'b010,
        C_LT = 3'b011,
        C_LE = 3'b100
    } cond_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_EVAL   = 2'b01,
        S_UPDATE = 2'b10
    } state_e;

    // Branch types that write the link register
    function automatic logic is_link(input logic [1:0] br_type);
        return (br_type == BR_L) || (br_type == BR_LX);
    endfunction

endpackage

// File: rtl/p6_cond_eval.sv
// Combinational condition evaluator: maps a Bcond code and the N/V/Z status to a taken decision.
module p6_cond_eval
    import p6_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       n,
    input  logic       v,
    input  logic       z,
    output logic       taken
);

    logic taken_s;

    // Condition decode; reserved codes are never taken
    always_comb begin
        taken_s = 1'b0;
        case (cond)
            C_AL:    taken_s = 1'b1;
            C_EQ:    taken_s = z;
            C_NE:    taken_s = ~z;
            C_LT:    taken_s = n ^ v;
            C_LE:    taken_s = (n ^ v) | z;
            default: taken_s = 1'b0;
        endcase
    end

    assign taken = taken_s;

endmodule

// File: rtl/p6_branch_unit.sv
// PC and status-register stage behind the p6 ALU: sequential fetch, conditional and
// register/link branches through an IDLE -> EVAL -> UPDATE handshake.
module p6_branch_unit
    import p6_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            N_in,
    input  logic            V_in,
    input  logic            Z_in,
    input  logic            load_s,
    input  logic            pc_inc,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [1:0]      br_type,
    input  logic [2:0]      cond,
    input  logic [15:0]     sximm8,
    input  logic [15:0]     rd_val,
    output logic [PC_W-1:0] pc,
    output logic            N,
    output logic            V,
    output logic            Z,
    output logic            taken,
    output logic            link_we,
    output logic [15:0]     link_data,
    output logic            br_done
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_e          state_r, state_nxt_s;
    logic [1:0]      type_r, type_nxt_s;
    logic [2:0]      cond_r, cond_nxt_s;
    logic [15:0]     imm_r, imm_nxt_s;
    logic [15:0]     rd_r, rd_nxt_s;
    logic [PC_W-1:0] pc_r, pc_nxt_s, pc_plus1_s;
    logic            n_r, v_r, z_r;
    logic            ready_r, ready_nxt_s;
    logic            taken_r, taken_nxt_s;
    logic            done_r, done_nxt_s;
    logic            link_we_r, link_we_nxt_s;
    logic [15:0]     link_data_r, link_data_nxt_s;
    logic            cond_taken_s;

    p6_cond_eval u_cond_eval (
        .cond  (cond_r),
        .n     (n_r),
        .v     (v_r),
        .z     (z_r),
        .taken (cond_taken_s)
    );

    assign pc_plus1_s = pc_r + PC_ONE;

    // Next-state, PC and output-register computation
    always_comb begin
        state_nxt_s     = state_r;
        type_nxt_s      = type_r;
        cond_nxt_s      = cond_r;
        imm_nxt_s       = imm_r;
        rd_nxt_s        = rd_r;
        pc_nxt_s        = pc_r;
        taken_nxt_s     = taken_r;
        done_nxt_s      = 1'b0;
        link_we_nxt_s   = 1'b0;
        link_data_nxt_s = link_data_r;
        case (state_r)
            S_IDLE: begin
                // An accepted branch takes priority over sequential fetch
                if (br_valid) begin
                    type_nxt_s  = br_type;
                    cond_nxt_s  = cond;
                    imm_nxt_s   = sximm8;
                    rd_nxt_s    = rd_val;
                    state_nxt_s = S_EVAL;
                end else if (pc_inc) begin
                    pc_nxt_s = pc_plus1_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            S_EVAL: begin
                taken_nxt_s   = (type_r == BR_COND) ? cond_taken_s : 1'b1;
                done_nxt_s    = 1'b1;
                link_we_nxt_s = is_link(type_r);
                if (is_link(type_r)) begin
                    link_data_nxt_s = 16'(pc_plus1_s);
                end else begin
                    link_data_nxt_s = link_data_r;
                end
                state_nxt_s = S_UPDATE;
            end
            S_UPDATE: begin
                taken_nxt_s = 1'b0;
                state_nxt_s = S_IDLE;
                case (type_r)
                    BR_COND: pc_nxt_s = taken_r ? (pc_plus1_s + imm_r[PC_W-1:0]) : pc_plus1_s;
                    BR_L:    pc_nxt_s = pc_plus1_s + imm_r[PC_W-1:0];
                    BR_X:    pc_nxt_s = rd_r[PC_W-1:0];
                    BR_LX:   pc_nxt_s = rd_r[PC_W-1:0];
                    default: pc_nxt_s = pc_plus1_s;
                endcase
            end
            default: state_nxt_s = S_IDLE;
        endcase
        ready_nxt_s = (state_nxt_s == S_IDLE);
    end

    // State, PC, status and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            type_r      <= 2'b00;
            cond_r      <= 3'b000;
            imm_r       <= 16'h0000;
            rd_r        <= 16'h0000;
            pc_r        <= RESET_PC;
            n_r         <= 1'b0;
            v_r         <= 1'b0;
            z_r         <= 1'b0;
            ready_r     <= 1'b1;
            taken_r     <= 1'b0;
            done_r      <= 1'b0;
            link_we_r   <= 1'b0;
            link_data_r <= 16'h0000;
        end else begin
            state_r     <= state_nxt_s;
            type_r      <= type_nxt_s;
            cond_r      <= cond_nxt_s;
            imm_r       <= imm_nxt_s;
            rd_r        <= rd_nxt_s;
            pc_r        <= pc_nxt_s;
            ready_r     <= ready_nxt_s;
            taken_r     <= taken_nxt_s;
            done_r      <= done_nxt_s;
            link_we_r   <= link_we_nxt_s;
            link_data_r <= link_data_nxt_s;
            if (load_s) begin
                n_r <= N_in;
                v_r <= V_in;
                z_r <= Z_in;
            end else begin
                n_r <= n_r;
                v_r <= v_r;
                z_r <= z_r;
            end
        end
    end

    assign br_ready  = ready_r;
    assign pc        = pc_r;
    assign N         = n_r;
    assign V         = v_r;
    assign Z         = z_r;
    assign taken     = taken_r;
    assign link_we   = link_we_r;
    assign link_data = link_data_r;
    assign br_done   = done_r;

endmodule

// File: tb/tb_p6_branch_unit.sv
// Directed-vector bench for p6_branch_unit with hand-computed expectations.
module tb_p6_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        N_in, V_in, Z_in, load_s, pc_inc, br_valid;
    logic        br_ready;
    logic [1:0]  br_type;
    logic [2:0]  cond;
    logic [15:0] sximm8, rd_val;
    logic [8:0]  pc;
    logic        N, V, Z, taken, link_we, br_done;
    logic [15:0] link_data;

    int checks = 0;
    int errors = 0;

    p6_branch_unit #(.PC_W(9), .RESET_PC(9'd0)) dut (
        .clk(clk), .reset(reset), .N_in(N_in), .V_in(V_in), .Z_in(Z_in),
        .load_s(load_s), .pc_inc(pc_inc), .br_valid(br_valid), .br_ready(br_ready),
        .br_type(br_type), .cond(cond), .sximm8(sximm8), .rd_val(rd_val),
        .pc(pc), .N(N), .V(V), .Z(Z), .taken(taken), .link_we(link_we),
        .link_data(link_data), .br_done(br_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic n, input logic v, input logic z);
        N_in = n; V_in = v; Z_in = z; load_s = 1'b1;
        tick();
        load_s = 1'b0;
    endtask

    // Drives one request and checks EVAL, UPDATE and the following IDLE cycle
    task automatic run_branch(input string tag, input logic [1:0] t, input logic [2:0] c,
                              input logic [15:0] imm, input logic [15:0] rd, input logic hold,
                              input logic [8:0] pc0, input logic exp_taken, input logic [8:0] exp_pc,
                              input logic exp_lwe, input logic [15:0] exp_ld);
        br_valid = 1'b1; br_type = t; cond = c; sximm8 = imm; rd_val = rd;
        tick();
        load_s = 1'b0;
        if (hold) begin
            pc_inc = 1'b1;
        end else begin
            br_valid = 1'b0;
            pc_inc   = 1'b0;
        end
        check({tag, "_eval_ready"}, br_ready, 1'b0);
        check({tag, "_eval_done"}, br_done, 1'b0);
        tick();
        check({tag, "_upd_done"}, br_done, 1'b1);
        check({tag, "_upd_taken"}, taken, exp_taken);
        check({tag, "_upd_lwe"}, link_we, exp_lwe);
        if (exp_lwe) check({tag, "_upd_ldata"}, link_data, exp_ld);
        check({tag, "_upd_pc"}, pc, pc0);
        check({tag, "_upd_ready"}, br_ready, 1'b0);
        br_valid = 1'b0;
        pc_inc   = 1'b0;
        tick();
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_done_off"}, br_done, 1'b0);
        check({tag, "_lwe_off"}, link_we, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; N_in = 1'b0; V_in = 1'b0; Z_in = 1'b0; load_s = 1'b0; pc_inc = 1'b0;
        br_valid = 1'b0; br_type = 2'b00; cond = 3'b000; sximm8 = 16'h0000; rd_val = 16'h0000;
        tick(); tick();
        reset = 1'b0;
        check("rst_pc", pc, 9'd0);
        check("rst_nvz", {N, V, Z}, 3'b000);
        check("rst_ready", br_ready, 1'b1);
        check("rst_done", br_done, 1'b0);
        check("rst_taken", taken, 1'b0);
        check("rst_lwe", link_we, 1'b0);
        check("rst_ldata", link_data, 16'h0000);

        pc_inc = 1'b1;
        repeat (3) tick();
        pc_inc = 1'b0;
        check("inc3_pc", pc, 9'd3);
        #3 reset = 1'b1;
        #1 check("async_rst_pc", pc, 9'd0);
        reset = 1'b0;
        tick();

        run_branch("blx", 2'b11, 3'b000, 16'h0000, 16'h0123, 1'b0, 9'd0, 1'b1, 9'h123, 1'b1, 16'd1);
        run_branch("bx10", 2'b10, 3'b000, 16'h0000, 16'd10, 1'b0, 9'h123, 1'b1, 9'd10, 1'b0, 16'd0);
        set_flags(1'b0, 1'b0, 1'b1);
        check("ld_z", {N, V, Z}, 3'b001);
        run_branch("beq", 2'b00, 3'b001, 16'hFFFC, 16'h0000, 1'b0, 9'd10, 1'b1, 9'd7, 1'b0, 16'd0);

        run_branch("bx20", 2'b10, 3'b000, 16'h0000, 16'd20, 1'b0, 9'd7, 1'b1, 9'd20, 1'b0, 16'd0);
        set_flags(1'b1, 1'b0, 1'b0);
        run_branch("blt", 2'b00, 3'b011, 16'd5, 16'h0000, 1'b0, 9'd20, 1'b1, 9'd26, 1'b0, 16'd0);
        run_branch("bx20b", 2'b10, 3'b000, 16'h0000, 16'd20, 1'b0, 9'd26, 1'b1, 9'd20, 1'b0, 16'd0);
        set_flags(1'b1, 1'b0, 1'b1);
        run_branch("bne", 2'b00, 3'b010, 16'd5, 16'h0000, 1'b0, 9'd20, 1'b0, 9'd21, 1'b0, 16'd0);
        run_branch("ble", 2'b00, 3'b100, 16'd2, 16'h0000, 1'b0, 9'd21, 1'b1, 9'd24, 1'b0, 16'd0);

        run_branch("bx40", 2'b10, 3'b000, 16'h0000, 16'd40, 1'b0, 9'd24, 1'b1, 9'd40, 1'b0, 16'd0);
        run_branch("bl", 2'b01, 3'b000, 16'd8, 16'h0000, 1'b0, 9'd40, 1'b1, 9'd49, 1'b1, 16'd41);
        run_branch("bx29", 2'b10, 3'b000, 16'h0000, 16'h0029, 1'b0, 9'd49, 1'b1, 9'd41, 1'b0, 16'd0);

        run_branch("bx511", 2'b10, 3'b000, 16'h0000, 16'd511, 1'b0, 9'd41, 1'b1, 9'd511, 1'b0, 16'd0);
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        check("wrap_pc", pc, 9'd0);
        run_branch("bx510", 2'b10, 3'b000, 16'h0000, 16'd510, 1'b0, 9'd0, 1'b1, 9'd510, 1'b0, 16'd0);
        run_branch("b_wrap", 2'b00, 3'b000, 16'd3, 16'h0000, 1'b0, 9'd510, 1'b1, 9'd2, 1'b0, 16'd0);
        run_branch("rsvd", 2'b00, 3'b110, 16'd9, 16'h0000, 1'b0, 9'd2, 1'b0, 9'd3, 1'b0, 16'd0);

        // Status is N=1 V=0 Z=1; acceptance cycle loads Z=0 and also requests pc_inc
        N_in = 1'b0; V_in = 1'b0; Z_in = 1'b0; load_s = 1'b1; pc_inc = 1'b1;
        run_branch("same_cyc", 2'b00, 3'b001, 16'd10, 16'h0000, 1'b0, 9'd3, 1'b0, 9'd4, 1'b0, 16'd0);
        check("same_cyc_nvz", {N, V, Z}, 3'b000);

        run_branch("hold", 2'b10, 3'b000, 16'h0000, 16'd100, 1'b1, 9'd4, 1'b1, 9'd100, 1'b0, 16'd0);
        tick();
        check("hold_no2nd_pc", pc, 9'd100);
        check("hold_no2nd_ready", br_ready, 1'b1);
        check("hold_no2nd_done", br_done, 1'b0);

        br_valid = 1'b1; br_type = 2'b00; cond = 3'b000; sximm8 = 16'd5;
        tick();
        br_valid = 1'b0;
        check("rst_eval_ready", br_ready, 1'b0);
        #2 reset = 1'b1;
        #1 check("rst_eval_pc", pc, 9'd0);
        reset = 1'b0;
        tick();
        check("rst_eval_done", br_done, 1'b0);
        check("rst_eval_ready2", br_ready, 1'b1);
        tick();
        check("rst_eval_pc2", pc, 9'd0);
        check("rst_eval_done2", br_done, 1'b0);
        check("rst_eval_lwe", link_we, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
